// File: rtl/matmul_calc_pkg.sv
// Shared parameters and state encoding for the matmul_calc APB requester.
package matmul_calc_pkg;

  localparam int MATMUL_ADDR_WIDTH     = 16;
  localparam int MATMUL_BUS_WIDTH      = 32;
  localparam int MATMUL_TIMEOUT_CYCLES = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    BUSYWAIT = 3'd1,
    SETUP    = 3'd2,
    ACCESS   = 3'd3,
    RESP     = 3'd4
  } apb_mst_state_t;

endpackage

// File: rtl/matmul_apb_master_if.sv
// Command/response channel plus APB requester signals toward matmul_calc.
interface matmul_apb_master_if
  import matmul_calc_pkg::*;
#(
  parameter int ADDR_WIDTH = MATMUL_ADDR_WIDTH,
  parameter int BUS_WIDTH  = MATMUL_BUS_WIDTH
);

  logic                    cmd_valid_i;
  logic                    cmd_ready_o;
  logic                    cmd_write_i;
  logic [ADDR_WIDTH-1:0]   cmd_addr_i;
  logic [BUS_WIDTH-1:0]    cmd_wdata_i;
  logic [BUS_WIDTH/8-1:0]  cmd_strb_i;

  logic                    rsp_valid_o;
  logic                    rsp_ready_i;
  logic [BUS_WIDTH-1:0]    rsp_rdata_o;
  logic                    rsp_err_o;
  logic                    rsp_timeout_o;

  logic                    psel_o;
  logic                    penable_o;
  logic                    pwrite_o;
  logic [ADDR_WIDTH-1:0]   paddr_o;
  logic [BUS_WIDTH-1:0]    pwdata_o;
  logic [BUS_WIDTH/8-1:0]  pstrb_o;
  logic                    pready_i;
  logic                    pslverr_i;
  logic [BUS_WIDTH-1:0]    prdata_i;
  logic                    busy_i;

  modport master (
    input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i,
    input  rsp_ready_i, pready_i, pslverr_i, prdata_i, busy_i,
    output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
    output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o
  );

  modport slave (
    output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i,
    output rsp_ready_i, pready_i, pslverr_i, prdata_i, busy_i,
    input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
    input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o
  );

endinterface

// File: rtl/matmul_apb_master.sv
// Single-outstanding APB requester: holds writes off while matmul_calc is busy,
// bounds ACCESS wait-states with a timeout, and returns one response per command.
module matmul_apb_master
  import matmul_calc_pkg::*;
#(
  parameter int ADDR_WIDTH     = MATMUL_ADDR_WIDTH,
  parameter int BUS_WIDTH      = MATMUL_BUS_WIDTH,
  parameter int TIMEOUT_CYCLES = MATMUL_TIMEOUT_CYCLES
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  matmul_apb_master_if.master bus
);

  localparam int STRB_WIDTH = BUS_WIDTH / 8;
  // A zero timeout still needs a legal (unused) counter width.
  localparam int CNT_WIDTH  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  apb_mst_state_t          state_q, state_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [BUS_WIDTH-1:0]    pwdata_q, pwdata_d;
  logic [STRB_WIDTH-1:0]   pstrb_q, pstrb_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [BUS_WIDTH-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    rsp_timeout_q, rsp_timeout_d;
  logic [CNT_WIDTH-1:0]    wait_cnt_q, wait_cnt_d;
  logic [CNT_WIDTH-1:0]    wait_cnt_inc;
  logic                    accept;

  assign accept       = bus.cmd_valid_i && cmd_ready_q;
  assign wait_cnt_inc = wait_cnt_q + CNT_WIDTH'(1);

  always_comb begin
    state_d       = state_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    wait_cnt_d    = wait_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          pwrite_d = bus.cmd_write_i;
          paddr_d  = bus.cmd_addr_i;
          pwdata_d = bus.cmd_wdata_i;
          pstrb_d  = bus.cmd_strb_i;
          state_d  = (bus.cmd_write_i && bus.busy_i) ? BUSYWAIT : SETUP;
        end
      end
      BUSYWAIT: begin
        if (!bus.busy_i) state_d = SETUP;
      end
      SETUP: begin
        wait_cnt_d = '0;
        state_d    = ACCESS;
      end
      ACCESS: begin
        // pready wins over the timeout when both land in the same cycle.
        if (bus.pready_i) begin
          rsp_rdata_d   = pwrite_q ? '0 : bus.prdata_i;
          rsp_err_d     = bus.pslverr_i;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = RESP;
        end else if ((TIMEOUT_CYCLES != 0) &&
                     (wait_cnt_inc == CNT_WIDTH'(TIMEOUT_CYCLES))) begin
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          state_d       = RESP;
        end else begin
          wait_cnt_d = wait_cnt_inc;
        end
      end
      RESP: begin
        if (bus.rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Bus strobes follow the next state so they come straight out of flops.
    psel_d      = (state_d == SETUP) || (state_d == ACCESS);
    penable_d   = (state_d == ACCESS);
    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      cmd_ready_q   <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  assign bus.cmd_ready_o   = cmd_ready_q;
  assign bus.psel_o        = psel_q;
  assign bus.penable_o     = penable_q;
  assign bus.pwrite_o      = pwrite_q;
  assign bus.paddr_o       = paddr_q;
  assign bus.pwdata_o      = pwdata_q;
  assign bus.pstrb_o       = pstrb_q;
  assign bus.rsp_valid_o   = rsp_valid_q;
  assign bus.rsp_rdata_o   = rsp_rdata_q;
  assign bus.rsp_err_o     = rsp_err_q;
  assign bus.rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_matmul_apb_master.sv
// Directed scoreboard bench for matmul_apb_master: a driver pushes expected
// responses, a negedge monitor pops and compares each response as it appears.
module tb_matmul_apb_master;

  typedef struct {
    logic        write;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rdata;
    logic        err;
    logic        to;
    int          accept_cyc;
    int          lat;
  } exp_t;

  logic clk;
  logic rst_ni;
  int   cyc;
  int   tests_run;
  int   fails;
  int   exp_cnt;
  int   rise_cnt;

  // APB completer model configuration (ws < 0 means pready never rises)
  int          cfg_ws;
  logic        cfg_err;
  logic [31:0] cfg_rdata;
  int          cfg_rsp_delay;
  int          ws_cnt;

  exp_t sb_q[$];

  // monitor state
  exp_t        mon_e;
  logic        mon_hold;
  int          mon_hold_cnt;
  int          mon_delay;
  int          mon_first;
  logic [31:0] snap_rdata;
  logic        snap_err;
  logic        snap_to;

  matmul_apb_master_if #(.ADDR_WIDTH(16), .BUS_WIDTH(32)) bif ();

  matmul_apb_master #(
    .ADDR_WIDTH    (16),
    .BUS_WIDTH     (32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  // APB completer: pready after cfg_ws wait-states of ACCESS
  always @(negedge clk) begin
    if (bif.psel_o && bif.penable_o) begin
      if (cfg_ws >= 0 && ws_cnt >= cfg_ws) begin
        bif.pready_i  = 1'b1;
        bif.pslverr_i = cfg_err;
        bif.prdata_i  = cfg_rdata;
      end else begin
        bif.pready_i  = 1'b0;
        bif.pslverr_i = 1'b0;
        bif.prdata_i  = 32'h0;
      end
      ws_cnt++;
    end else begin
      bif.pready_i  = 1'b0;
      bif.pslverr_i = 1'b0;
      bif.prdata_i  = 32'h0;
      ws_cnt = 0;
    end
  end

  // Response monitor / scoreboard checker; also acts as the response sink
  always @(negedge clk) begin
    if (bif.rsp_valid_o) begin
      if (!mon_hold) begin
        mon_hold     = 1'b1;
        mon_hold_cnt = 0;
        mon_delay    = cfg_rsp_delay;
        mon_first    = cyc + 1;
        rise_cnt++;
        snap_rdata   = bif.rsp_rdata_o;
        snap_err     = bif.rsp_err_o;
        snap_to      = bif.rsp_timeout_o;
        if (sb_q.size() == 0) begin
          tests_run++;
          fails++;
          $display("FAIL unexpected_rsp: got rdata 0x%0h, required no response", bif.rsp_rdata_o);
        end else begin
          mon_e = sb_q.pop_front();
          $display("rsp  addr=0x%0h write=%0b rdata=0x%0h err=%0b to=%0b lat=%0d",
                   mon_e.addr, mon_e.write, bif.rsp_rdata_o, bif.rsp_err_o,
                   bif.rsp_timeout_o, mon_first - mon_e.accept_cyc);
          check("rsp_rdata",   bif.rsp_rdata_o, mon_e.rdata);
          check("rsp_err",     32'(bif.rsp_err_o), 32'(mon_e.err));
          check("rsp_timeout", 32'(bif.rsp_timeout_o), 32'(mon_e.to));
          check("rsp_latency", 32'(mon_first - mon_e.accept_cyc), 32'(mon_e.lat));
          check("paddr",       32'(bif.paddr_o), 32'(mon_e.addr));
          check("pwrite",      32'(bif.pwrite_o), 32'(mon_e.write));
          check("pwdata",      bif.pwdata_o, mon_e.wdata);
          check("pstrb",       32'(bif.pstrb_o), 32'(mon_e.strb));
          check("cmd_ready_in_resp", 32'(bif.cmd_ready_o), 32'h0);
        end
      end else begin
        check("rsp_rdata_stable",   bif.rsp_rdata_o, snap_rdata);
        check("rsp_err_stable",     32'(bif.rsp_err_o), 32'(snap_err));
        check("rsp_timeout_stable", 32'(bif.rsp_timeout_o), 32'(snap_to));
        check("cmd_ready_hold",     32'(bif.cmd_ready_o), 32'h0);
      end
      bif.rsp_ready_i = (mon_hold_cnt >= mon_delay);
      mon_hold_cnt++;
    end else begin
      mon_hold        = 1'b0;
      bif.rsp_ready_i = 1'b0;
    end
  end

  // Caller is at a negedge; returns at the negedge after the acceptance edge.
  task automatic send(input logic wr, input logic [15:0] addr, input logic [31:0] wd,
                      input logic [3:0] st, input logic [31:0] erd, input logic eerr,
                      input logic eto, input int lat, output int acc);
    exp_t e;
    int n;
    bif.cmd_valid_i = 1'b1;
    bif.cmd_write_i = wr;
    bif.cmd_addr_i  = addr;
    bif.cmd_wdata_i = wd;
    bif.cmd_strb_i  = st;
    n = 0;
    while (!bif.cmd_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bif.cmd_ready_o) begin
      tests_run++;
      fails++;
      $display("FAIL cmd_accept_wait: got cmd_ready_o 0 after %0d cycles, required 1", n);
      bif.cmd_valid_i = 1'b0;
      acc = -1;
      return;
    end
    e.write      = wr;
    e.addr       = addr;
    e.wdata      = wd;
    e.strb       = st;
    e.rdata      = erd;
    e.err        = eerr;
    e.to         = eto;
    e.accept_cyc = cyc + 1;
    e.lat        = lat;
    sb_q.push_back(e);
    exp_cnt++;
    acc = e.accept_cyc;
    $display("cmd  addr=0x%0h write=%0b wdata=0x%0h strb=0x%0h accept_cyc=%0d",
             addr, wr, wd, st, acc);
    @(negedge clk);
    bif.cmd_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || !bif.cmd_ready_o) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0 || !bif.cmd_ready_o) begin
      tests_run++;
      fails++;
      $display("FAIL drain_wait: got %0d pending responses, required 0", sb_q.size());
    end
  endtask

  initial begin
    int acc1;
    int acc2;
    int n;

    tests_run = 0; fails = 0; exp_cnt = 0; rise_cnt = 0; cyc = 0;
    mon_hold = 1'b0; mon_hold_cnt = 0; mon_delay = 0; mon_first = 0; ws_cnt = 0;
    cfg_ws = 0; cfg_err = 1'b0; cfg_rdata = 32'h0; cfg_rsp_delay = 0;
    rst_ni = 1'b0;
    bif.cmd_valid_i = 1'b0; bif.cmd_write_i = 1'b0; bif.cmd_addr_i = '0;
    bif.cmd_wdata_i = '0;   bif.cmd_strb_i  = '0;   bif.rsp_ready_i = 1'b0;
    bif.pready_i = 1'b0;    bif.pslverr_i = 1'b0;   bif.prdata_i = '0;
    bif.busy_i = 1'b0;

    #3;
    check("reset_psel",        32'(bif.psel_o), 32'h0);
    check("reset_penable",     32'(bif.penable_o), 32'h0);
    check("reset_pwrite",      32'(bif.pwrite_o), 32'h0);
    check("reset_paddr",       32'(bif.paddr_o), 32'h0);
    check("reset_pwdata",      bif.pwdata_o, 32'h0);
    check("reset_pstrb",       32'(bif.pstrb_o), 32'h0);
    check("reset_rsp_valid",   32'(bif.rsp_valid_o), 32'h0);
    check("reset_rsp_err",     32'(bif.rsp_err_o), 32'h0);
    check("reset_rsp_timeout", 32'(bif.rsp_timeout_o), 32'h0);
    check("reset_rsp_rdata",   bif.rsp_rdata_o, 32'h0);
    check("reset_cmd_ready",   32'(bif.cmd_ready_o), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    check("cmd_ready_after_reset", 32'(bif.cmd_ready_o), 32'h1);

    // zero-wait write
    send(1'b1, 16'h0004, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 1'b0, 3, acc1);
    drain();

    // read with 3 wait-states
    cfg_ws = 3; cfg_rdata = 32'h12345678;
    send(1'b0, 16'h0010, 32'h0, 4'h0, 32'h12345678, 1'b0, 1'b0, 6, acc1);
    drain();

    // write held off by busy_i for 5 cycles
    cfg_ws = 0;
    bif.busy_i = 1'b1;
    send(1'b1, 16'h0020, 32'hA5A50F0F, 4'h5, 32'h0, 1'b0, 1'b0, 8, acc1);
    check("busywait_psel", 32'(bif.psel_o), 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("busywait_psel", 32'(bif.psel_o), 32'h0);
    end
    bif.busy_i = 1'b0;
    @(negedge clk);
    check("setup_psel",    32'(bif.psel_o), 32'h1);
    check("setup_penable", 32'(bif.penable_o), 32'h0);
    drain();

    // read ignores busy_i
    bif.busy_i = 1'b1; cfg_rdata = 32'hCAFEF00D;
    send(1'b0, 16'h0030, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 1'b0, 3, acc1);
    drain();
    bif.busy_i = 1'b0;

    // timeout: pready never rises
    cfg_ws = -1; cfg_rdata = 32'hFFFFFFFF;
    send(1'b0, 16'h0040, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, 18, acc1);
    drain();

    // pready in the 16th ACCESS cycle completes normally
    cfg_ws = 15; cfg_rdata = 32'h5A5A5A5A;
    send(1'b0, 16'h0044, 32'h0, 4'h0, 32'h5A5A5A5A, 1'b0, 1'b0, 18, acc1);
    drain();

    // slave error on a write, response held for 4 cycles
    cfg_ws = 0; cfg_err = 1'b1; cfg_rsp_delay = 4;
    send(1'b1, 16'h0050, 32'h01020304, 4'h3, 32'h0, 1'b1, 1'b0, 3, acc1);
    drain();

    // slave error on a read keeps the read data
    cfg_ws = 1; cfg_rsp_delay = 0; cfg_rdata = 32'h0BAD0BAD;
    send(1'b0, 16'h0054, 32'h0, 4'h0, 32'h0BAD0BAD, 1'b1, 1'b0, 4, acc1);
    drain();
    cfg_err = 1'b0;

    // back-to-back zero-wait reads
    cfg_ws = 0; cfg_rdata = 32'h77778888;
    send(1'b0, 16'h0060, 32'h0, 4'h0, 32'h77778888, 1'b0, 1'b0, 3, acc1);
    send(1'b0, 16'h0064, 32'h0, 4'h0, 32'h77778888, 1'b0, 1'b0, 3, acc2);
    check("b2b_spacing", 32'(acc2 - acc1), 32'd4);
    drain();

    // reset asserted during ACCESS discards the transfer
    cfg_ws = -1;
    bif.cmd_valid_i = 1'b1; bif.cmd_write_i = 1'b0; bif.cmd_addr_i = 16'h0070;
    n = 0;
    while (!bif.cmd_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    bif.cmd_valid_i = 1'b0;
    n = 0;
    while (!bif.penable_o && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("pre_reset_penable", 32'(bif.penable_o), 32'h1);
    #2 rst_ni = 1'b0;
    #1;
    check("async_reset_psel",      32'(bif.psel_o), 32'h0);
    check("async_reset_penable",   32'(bif.penable_o), 32'h0);
    check("async_reset_rsp_valid", 32'(bif.rsp_valid_o), 32'h0);
    check("async_reset_cmd_ready", 32'(bif.cmd_ready_o), 32'h0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    check("cmd_ready_after_midreset", 32'(bif.cmd_ready_o), 32'h1);
    repeat (25) @(negedge clk);

    // normal operation resumes
    cfg_ws = 2;
    send(1'b1, 16'h007E, 32'hFFFF0000, 4'hC, 32'h0, 1'b0, 1'b0, 5, acc1);
    drain();

    check("response_count", 32'(rise_cnt), 32'(exp_cnt));

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/matmul_apb_master.md
MATMUL_APB_MASTER -- requirements
Module: matmul_apb_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, APB address width.
REQ-002 SHALL have parameter BUS_WIDTH, default 32, APB data width; strobe width is BUS_WIDTH/8.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum ACCESS wait-states; 0 disables the timeout.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk_i  in  1  clock (rising edge); rst_ni  in  1  asynchronous active-low reset.
REQ-005 cmd_valid_i  in  1  command request.
REQ-006 cmd_ready_o  out  1  command accepted when both cmd_valid_i and cmd_ready_o are high.
REQ-007 cmd_write_i  in  1  1=write, 0=read.
REQ-008 cmd_addr_i  in  ADDR_WIDTH  target address.
REQ-009 cmd_wdata_i  in  BUS_WIDTH  write data.
REQ-010 cmd_strb_i  in  BUS_WIDTH/8  write byte strobes.
REQ-011 rsp_valid_o  out  1  response available; rsp_ready_i  in  1  response consumed.
REQ-012 rsp_rdata_o  out  BUS_WIDTH  read data; rsp_err_o  out  1  pslverr or timeout; rsp_timeout_o  out  1  timeout flag.
REQ-013 psel_o, penable_o, pwrite_o  out  1 each; paddr_o  out  ADDR_WIDTH; pwdata_o  out  BUS_WIDTH; pstrb_o  out  BUS_WIDTH/8: APB requester outputs toward matmul_calc.
REQ-014 pready_i, pslverr_i  in  1 each; prdata_i  in  BUS_WIDTH; busy_i  in  1  matmul_calc busy.

Function
REQ-015 SHALL implement FSM states IDLE, BUSYWAIT, SETUP, ACCESS, RESP.
REQ-016 cmd_ready_o SHALL be 1 only in IDLE; on acceptance, write/addr/wdata/strb SHALL be registered, and the registered values SHALL drive pwrite_o/paddr_o/pwdata_o/pstrb_o until the next acceptance.
REQ-017 IDLE -> SETUP on acceptance of a read, or of a write when busy_i=0; IDLE -> BUSYWAIT on acceptance of a write when busy_i=1.
REQ-018 BUSYWAIT -> SETUP on the first cycle with busy_i=0; psel_o=0 throughout BUSYWAIT; reads never enter BUSYWAIT.
REQ-019 SETUP: psel_o=1, penable_o=0, lasting exactly one cycle, then ACCESS.
REQ-020 ACCESS: psel_o=1, penable_o=1; on pready_i=1, capture prdata_i (reads only; writes capture 0) and pslverr_i, then -> RESP.
REQ-021 Zero-wait transfer: rsp_valid_o SHALL rise exactly 3 cycles after the acceptance edge; each pready_i=0 ACCESS cycle adds one cycle.
REQ-022 A wait counter SHALL count consecutive ACCESS cycles with pready_i=0; when it reaches TIMEOUT_CYCLES, -> RESP with rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0; pready_i=1 in the cycle the limit is reached takes priority (normal completion).
REQ-023 RESP: psel_o=penable_o=0, rsp_valid_o=1 with stable rsp_* until rsp_ready_i=1; then -> IDLE.
REQ-024 rsp_err_o SHALL equal captured pslverr_i OR timeout; rsp_timeout_o=0 on a normal completion.
REQ-025 No new command SHALL be accepted in the cycle of the response handshake; the minimum back-to-back command spacing is 4 cycles.
REQ-026 psel_o/penable_o SHALL be registered outputs, glitch-free.

Reset
REQ-027 On rst_ni=0, asynchronously: state=IDLE; psel_o, penable_o, pwrite_o, rsp_valid_o, rsp_err_o, rsp_timeout_o all 0; paddr_o, pwdata_o, pstrb_o, rsp_rdata_o all 0; wait counter 0; cmd_ready_o=0 during reset, 1 after release.
REQ-028 Reset mid-transfer SHALL drop psel_o/penable_o immediately and discard the in-flight command and any pending response.

Structure
REQ-029 ADDR_WIDTH, BUS_WIDTH, TIMEOUT_CYCLES defaults and the state enum apb_mst_state_t SHALL live in matmul_calc_pkg.
REQ-030 Single flat module; no sub-module is needed; the counter width is $clog2(TIMEOUT_CYCLES+1).

Verification
REQ-031 Write addr 0x0004, data 0xDEADBEEF, strb 0xF, busy_i=0, pready_i=1 immediately -> SETUP at T+1, ACCESS at T+2, rsp_valid_o at T+3, rsp_err_o=0.
REQ-032 Read addr 0x0010, pready_i after 3 wait-states, prdata_i=0x12345678 -> rsp_rdata_o=0x12345678, rsp_valid_o at T+6.
REQ-033 Write with busy_i=1 for 5 cycles -> psel_o stays 0 for those 5 cycles, then SETUP; a read under busy_i=1 proceeds with no delay.
REQ-034 pready_i never asserted, TIMEOUT_CYCLES=16 -> RESP after 16 ACCESS cycles, rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0.
REQ-035 pslverr_i=1 with pready_i=1 -> rsp_err_o=1, rsp_timeout_o=0; rsp_ready_i held 0 for 4 cycles -> rsp_* stable and cmd_ready_o=0 throughout.
REQ-036 rst_ni asserted during ACCESS -> psel_o=penable_o=0 without waiting for a clock edge; after release, cmd_ready_o=1 and no response is issued.
